mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one multi-cycle unified memory port between the instruction-fetch requester (IF stage, read-only) and the data requester (MEM stage, read/write) of the 5-stage pipelined CPU.
- Owns a grant FSM with fixed data-over-fetch priority.
- Drives the memory-side request/acknowledge handshake and returns one-cycle acknowledge pulses with registered read data.
- Raises a pipeline-wide stall while any requester is waiting.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width of read/write data
- TIMEOUT, 64, cycles without mem_ack_i before a transaction is aborted (used only with the optional feature)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  run enable; low blocks new grants
- if_req_i  in  1  fetch request, held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_ack_o  out  1  one-cycle fetch completion pulse
- if_rdata_o  out  DATA_W  fetched instruction, valid while if_ack_o=1
- dm_req_i  in  1  data request, held until dm_ack_o
- dm_we_i  in  1  1=write, 0=read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_ack_o  out  1  one-cycle data completion pulse
- dm_rdata_o  out  DATA_W  load data, valid while dm_ack_o=1
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ack_i  in  1  memory completion; mem_rdata_i valid in same cycle
- mem_rdata_i  in  DATA_W  memory read data
- stall_o  out  1  pipeline stall, combinational
- err_o  out  1  timeout error pulse (optional feature)

Behaviour:
- Interface rule: one clock clk_i; reset rst_i is asynchronous and active-high.
- Reset values: state=IDLE. The following are 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_ack_o, dm_ack_o, if_rdata_o, dm_rdata_o, err_o.
- Reset asserted mid-transaction: immediately forces mem_req_o=0. A late mem_ack_i after reset is ignored.
- FSM states: IDLE, IF_BUSY, DM_BUSY, RESP.
- IDLE, start_i=1, dm_req_i=1:
  - latch dm_we_i/dm_addr_i/dm_wdata_i into mem_*_o, set mem_req_o=1, go to DM_BUSY.
  - Applies even when if_req_i=1: data wins.
- IDLE, start_i=1, dm_req_i=0, if_req_i=1: latch if_addr_i, mem_we_o=0, mem_wdata_o=0, mem_req_o=1, go to IF_BUSY.
- IDLE, start_i=0 or no request: stay in IDLE. mem_ack_i ignored.
- IF_BUSY/DM_BUSY, mem_ack_i=1:
  - mem_req_o←0, mem_we_o←0.
  - Register mem_rdata_i into the granted requester's rdata_o; assert that requester's ack_o for exactly one cycle.
  - Go to RESP.
- IF_BUSY/DM_BUSY, mem_ack_i=0: hold all mem_*_o stable.
- RESP: ack pulse cycle.
  - Requests ignored in this cycle; the pipeline advances at its end.
  - Unconditionally go to IDLE.
  - mem_ack_i ignored.
- rdata_o holds its value after the ack pulse until the next completion for that requester. Writes leave dm_rdata_o unchanged.
- Latency:
  - request sampled at edge E0 → mem_req_o high from E0.
  - mem_ack_i in the cycle after E0 → ack_o high in the following cycle.
  - Minimum 2 cycles from request to ack; +1 per memory wait cycle.
- stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).
- Back-to-back requests: IF waiting behind DM is granted on the first IDLE cycle after DM's RESP. No request is ever issued twice.
- Requester dropping req before ack is illegal. The transaction still completes and the ack is still pulsed.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - an 8-bit-or-wider counter clears on entry to a BUSY state and increments each BUSY cycle with mem_ack_i=0.
  - When it reaches TIMEOUT: mem_req_o←0, the granted ack_o pulses with rdata_o=0, err_o pulses one cycle (aligned with ack), go to RESP.
  - mem_ack_i arriving in the same cycle as expiry takes precedence: normal completion, no err_o.
- When not defined: BUSY waits indefinitely, no counter, err_o tied 0.

Test Plan:
- Reset mid-DM_BUSY (mem_req_o=1, addr 0x40) → mem_req_o=0 immediately, state IDLE; mem_ack_i next cycle produces no ack.
- if_req_i=1, if_addr_i=0x8, zero-wait memory returning 0x00500093 → mem_addr_o=0x8, if_ack_o pulse 2 cycles after request, if_rdata_o=0x00500093, stall_o=1 until the ack cycle.
- if_req_i and dm_req_i both high, dm read 0x100 → data granted first; dm_ack_o with dm_rdata_o=mem_rdata_i; then fetch issued on the next IDLE; each address appears on mem_addr_o exactly once.
- dm write addr 0x20 data 0xDEADBEEF, memory 3 wait cycles → mem_we_o=1 and mem_wdata_o=0xDEADBEEF stable 4 cycles; dm_ack_o 5 cycles after request; dm_rdata_o unchanged.
- start_i=0 with if_req_i=1 → mem_req_o stays 0, stall_o=1; raising start_i → grant on the next edge.
- ARB_TIMEOUT_EN, TIMEOUT=4, memory never acks → err_o and if_ack_o pulse together after 4 BUSY cycles, if_rdata_o=0, FSM returns to IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle memory port between the
// instruction-fetch requester (read-only) and the data requester (read/write).
// Data always wins over fetch. Each completion returns a one-cycle ack pulse
// with registered read data; stall_o is high while any requester waits.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i                 run enable, low blocks new grants
//   if_req_i/if_addr_i      fetch request and address
//   if_ack_o/if_rdata_o     fetch completion pulse and instruction
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i  data request
//   dm_ack_o/dm_rdata_o     data completion pulse and load data
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  memory-side request
//   mem_ack_i/mem_rdata_i   memory completion and read data
//   stall_o                 combinational pipeline stall
//   err_o                   timeout error pulse
//
// Optional feature: define ARB_TIMEOUT_EN to abort a BUSY transaction after
// TIMEOUT cycles without mem_ack_i (ack pulses with zero data, err_o pulses).
// Without it BUSY waits indefinitely and err_o is tied low.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              mem_req_d, mem_we_d, if_ack_d, dm_ack_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, dm_rdata_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_d;
`else
  // TIMEOUT only matters with the timeout feature; keep it referenced.
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

  // Stall while a request is outstanding and not being acknowledged this cycle.
  assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_o;
    mem_we_d    = mem_we_o;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_o;
    dm_rdata_d  = dm_rdata_o;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_i && dm_req_i) begin
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          state_d     = DM_BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end else if (start_i && if_req_i) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          state_d     = IF_BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      IF_BUSY, DM_BUSY: begin
        // A memory ack in the expiry cycle completes normally.
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESP;
          if (state_q == IF_BUSY) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata_i;
          end else begin
            dm_ack_d = 1'b1;
            if (!mem_we_o) dm_rdata_d = mem_rdata_i;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
          state_d   = RESP;
          if (state_q == IF_BUSY) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_o   <= mem_req_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
      if_ack_o    <= if_ack_d;
      dm_ack_o    <= dm_ack_d;
      if_rdata_o  <= if_rdata_d;
      dm_rdata_o  <= dm_rdata_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Wait-cycle counter and error pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_o <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_o <= err_d;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps plus randomized
// transactions checked against a transaction-level timing/data model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i, start_i;
  logic          if_req_i, if_ack_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          dm_req_i, dm_we_i, dm_ack_o;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i, dm_rdata_o;
  logic          mem_req_o, mem_we_o, mem_ack_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic          stall_o, err_o;

  // Memory-side drive: automatic responder or manual control.
  bit            resp_en = 1'b0;
  logic          r_ack = 1'b0, m_ack = 1'b0;
  logic [DW-1:0] r_rdata = '0, m_rdata = '0;
  assign mem_ack_i   = resp_en ? r_ack : m_ack;
  assign mem_rdata_i = resp_en ? r_rdata : m_rdata;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic          we;
    logic [DW-1:0] d;
  } req_t;

  int            wq[$];
  req_t          log_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] exp_if_rdata = '0, exp_dm_rdata = '0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Memory contents: written words, otherwise an address-derived pattern.
  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory responder: logs each issued request, checks it stays stable,
  // and acks after the wait count queued for it.
  logic [AW-1:0] cur_a;
  logic [DW-1:0] cur_d;
  logic          cur_we;
  int            cur_w, cur_n;
  bit            active = 1'b0;
  always @(negedge clk_i) begin
    if (rst_i || !resp_en) begin
      active = 1'b0;
      r_ack  = 1'b0;
    end else if (r_ack) begin
      r_ack = 1'b0;
    end else if (mem_req_o) begin
      if (!active) begin
        active = 1'b1;
        cur_a  = mem_addr_o;
        cur_we = mem_we_o;
        cur_d  = mem_wdata_o;
        cur_n  = 0;
        cur_w  = (wq.size() > 0) ? wq.pop_front() : 0;
        log_q.push_back('{cur_a, cur_we, cur_d});
      end else begin
        chk("mem_addr_stable", mem_addr_o, cur_a);
        chk("mem_we_stable", 32'(mem_we_o), 32'(cur_we));
        chk("mem_wdata_stable", mem_wdata_o, cur_d);
      end
      if (cur_n == cur_w) begin
        r_ack   = 1'b1;
        r_rdata = cur_we ? 32'h0 : rd(cur_a);
        if (cur_we) mem[cur_a] = cur_d;
        active  = 1'b0;
      end else begin
        cur_n++;
      end
    end
  end

  // One scenario: optional data and/or fetch request raised together,
  // start_i held low for s cycles, memory waits wdl (data) and wi (fetch).
  task automatic run_txn(input string tag, input bit use_if, input bit use_dm, input bit we,
                         input logic [AW-1:0] ia, input logic [AW-1:0] da,
                         input logic [DW-1:0] wdat, input int wi, input int wdl, input int s);
    int t_if, t_dm, t_end, idx;
    logic [DW-1:0] e_if, e_dm;
    bit if_p, dm_p, ea_if, ea_dm;
    wq.delete();
    log_q.delete();
    if (use_dm) wq.push_back(wdl);
    if (use_if) wq.push_back(wi);
    e_dm  = (use_dm && !we) ? rd(da) : exp_dm_rdata;
    e_if  = (use_dm && we && da == ia) ? wdat : rd(ia);
    t_dm  = s + 2 + wdl;
    t_if  = use_dm ? (s + 5 + wdl + wi) : (s + 2 + wi);
    t_end = use_if ? t_if : t_dm;
    if (use_dm && t_dm > t_end) t_end = t_dm;
    t_end += 2;
    start_i = (s == 0); if_req_i = use_if; if_addr_i = ia;
    dm_req_i = use_dm; dm_we_i = we; dm_addr_i = da; dm_wdata_i = wdat;
    if_p = use_if; dm_p = use_dm;
    for (int n = 1; n <= t_end; n++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      ea_if = use_if && (n == t_if);
      ea_dm = use_dm && (n == t_dm);
      if (ea_if) exp_if_rdata = e_if;
      if (ea_dm && !we) exp_dm_rdata = e_dm;
      chk({tag, ":if_ack"}, 32'(if_ack_o), 32'(ea_if));
      chk({tag, ":dm_ack"}, 32'(dm_ack_o), 32'(ea_dm));
      chk({tag, ":if_rdata"}, if_rdata_o, exp_if_rdata);
      chk({tag, ":dm_rdata"}, dm_rdata_o, exp_dm_rdata);
      chk({tag, ":stall"}, 32'(stall_o), 32'((if_p && !ea_if) || (dm_p && !ea_dm)));
      chk({tag, ":err"}, 32'(err_o), 32'h0);
      if (n <= s) chk({tag, ":no_grant"}, 32'(mem_req_o), 32'h0);
      if (n == s + 1) begin
        chk({tag, ":grant_req"}, 32'(mem_req_o), 32'h1);
        chk({tag, ":grant_addr"}, mem_addr_o, use_dm ? da : ia);
        chk({tag, ":grant_we"}, 32'(mem_we_o), 32'(use_dm && we));
      end
      if (ea_if) begin if_p = 1'b0; if_req_i = 1'b0; end
      if (ea_dm) begin dm_p = 1'b0; dm_req_i = 1'b0; end
      if (n == s) start_i = 1'b1;
    end
    chk({tag, ":issued"}, 32'(log_q.size()), 32'(int'(use_if) + int'(use_dm)));
    idx = 0;
    if (use_dm && log_q.size() > idx) begin
      chk({tag, ":log_dm_addr"}, log_q[idx].a, da);
      chk({tag, ":log_dm_wdata"}, log_q[idx].d, wdat);
      idx++;
    end
    if (use_if && log_q.size() > idx) begin
      chk({tag, ":log_if_addr"}, log_q[idx].a, ia);
      chk({tag, ":log_if_wdata"}, log_q[idx].d, 32'h0);
    end
  endtask

  initial begin
    bit e, ui, ud;
    rst_i = 1'b1; start_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    repeat (3) @(negedge clk_i);

    // Reset values.
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_mem_we", 32'(mem_we_o), 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);
    chk("rst_if_ack", 32'(if_ack_o), 32'h0);
    chk("rst_dm_ack", 32'(dm_ack_o), 32'h0);
    chk("rst_if_rdata", if_rdata_o, 32'h0);
    chk("rst_dm_rdata", dm_rdata_o, 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    rst_i = 1'b0;

    // Reset in the middle of a data transaction.
    start_i = 1'b1; dm_req_i = 1'b1; dm_addr_i = 32'h40;
    @(negedge clk_i);
    chk("midrst_req_before", 32'(mem_req_o), 32'h1);
    chk("midrst_addr_before", mem_addr_o, 32'h40);
    #2 rst_i = 1'b1;
    #1 chk("midrst_req_async", 32'(mem_req_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0; dm_req_i = 1'b0; m_ack = 1'b1; m_rdata = 32'hBAD0_BAD0;
    @(negedge clk_i);
    chk("midrst_late_dm_ack", 32'(dm_ack_o), 32'h0);
    chk("midrst_late_if_ack", 32'(if_ack_o), 32'h0);
    chk("midrst_late_req", 32'(mem_req_o), 32'h0);
    chk("midrst_late_rdata", dm_rdata_o, 32'h0);
    m_ack = 1'b0;
    @(negedge clk_i);
    chk("midrst_late_dm_ack2", 32'(dm_ack_o), 32'h0);
    resp_en = 1'b1;

    // Directed scenarios.
    mem[32'h8] = 32'h0050_0093;
    run_txn("fetch0", 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0, 0, 0, 0);
    run_txn("both", 1'b1, 1'b1, 1'b0, 32'hC, 32'h100, 32'h0, 0, 0, 0);
    run_txn("write3", 1'b0, 1'b1, 1'b1, 32'h0, 32'h20, 32'hDEAD_BEEF, 0, 3, 0);
    run_txn("startlow", 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 0, 0, 2);

`ifdef ARB_TIMEOUT_EN
    // Fetch that memory never acknowledges.
    resp_en = 1'b0; m_ack = 1'b0; start_i = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h30;
    for (int n = 1; n <= int'(TO) + 2; n++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      e = (n == int'(TO) + 1);
      if (e) exp_if_rdata = 32'h0;
      chk("to_if_ack", 32'(if_ack_o), 32'(e));
      chk("to_err", 32'(err_o), 32'(e));
      chk("to_if_rdata", if_rdata_o, exp_if_rdata);
      if (n <= int'(TO)) chk("to_req_held", 32'(mem_req_o), 32'h1);
      else chk("to_req_dropped", 32'(mem_req_o), 32'h0);
      if (e) if_req_i = 1'b0;
    end
    // Memory ack in the expiry cycle completes normally.
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h44; m_rdata = 32'hCAFE_F00D;
    for (int n = 1; n <= int'(TO) + 2; n++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      e = (n == int'(TO) + 1);
      if (e) exp_dm_rdata = 32'hCAFE_F00D;
      chk("race_dm_ack", 32'(dm_ack_o), 32'(e));
      chk("race_err", 32'(err_o), 32'h0);
      chk("race_dm_rdata", dm_rdata_o, exp_dm_rdata);
      if (e) dm_req_i = 1'b0;
      m_ack = (n == int'(TO));
    end
    m_ack = 1'b0;
    resp_en = 1'b1;
`endif

    // Randomized scenarios.
    for (int k = 0; k < 40; k++) begin
      ud = 1'($urandom_range(0, 1));
      ui = ud ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn("rand", ui, ud, 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 15)) << 2, 32'($urandom_range(0, 15)) << 2,
              32'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
